program_loader: RTL and testbench

//  Byte-stream instruction loader that is the writer side of the processor's instruction memory.
//  - Accepts a big-endian byte stream over valid/ready.
//  - Packs each 4 bytes into one 32-bit instruction word and writes the words to consecutive addresses from 0.
//  - Holds the processor until the HLT word (32'h0000_0000) has been written, then pulses start.
//  - Replaces hierarchical memory preloading so programs can be loaded from a host link.

---
 rtl/program_loader.sv | 157 +++++++++++++++
 tb/tb_program_loader.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/program_loader.sv
// Byte-stream instruction loader: packs big-endian bytes into 32-bit words, writes them to
// instruction memory from address 0 and releases the processor after HLT. Optional macro: CHECKSUM_EN.
module program_loader #(
   parameter int ADDR_WIDTH = 10
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  load_start,
   input  logic [7:0]            byte_data,
   input  logic                  byte_valid,
   output logic                  byte_ready,
   output logic                  imem_write_enable,
   output logic [ADDR_WIDTH-1:0] imem_write_address,
   output logic [31:0]           imem_write_data,
   output logic                  processor_hold,
   output logic                  processor_start,
   output logic [ADDR_WIDTH:0]   words_loaded,
   output logic                  load_done,
   output logic                  load_error
);

   localparam int MAX_WORDS = 2 ** ADDR_WIDTH;
   localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(MAX_WORDS - 1);
   localparam logic [ADDR_WIDTH-1:0] ADDR_ONE  = ADDR_WIDTH'(1);
   localparam logic [ADDR_WIDTH:0]   WORDS_ONE = (ADDR_WIDTH + 1)'(1);

`ifdef CHECKSUM_EN
   typedef enum logic [2:0] {
      S_IDLE, S_RECEIVE, S_WRITE, S_START, S_DONE, S_ERROR, S_CHECK
   } state_t;
`else
   typedef enum logic [2:0] {
      S_IDLE, S_RECEIVE, S_WRITE, S_START, S_DONE, S_ERROR
   } state_t;
`endif

   state_t                state_q, state_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [31:0]           word_q, word_d;
   logic [1:0]            bcnt_q, bcnt_d;
   logic [ADDR_WIDTH:0]   words_q, words_d;
`ifdef CHECKSUM_EN
   logic [7:0]            xor_q, xor_d;
`endif

   logic accept;
   logic restart;

`ifdef CHECKSUM_EN
   assign byte_ready = ((state_q == S_RECEIVE) || (state_q == S_CHECK)) && !load_start;
`else
   assign byte_ready = (state_q == S_RECEIVE) && !load_start;
`endif
   assign accept = byte_valid && byte_ready;

   assign imem_write_enable  = (state_q == S_WRITE);
   assign imem_write_address = addr_q;
   assign imem_write_data    = word_q;
   assign processor_hold     = !((state_q == S_START) || (state_q == S_DONE));
   assign processor_start    = (state_q == S_START);
   assign load_done          = (state_q == S_DONE);
   assign load_error         = (state_q == S_ERROR);
   assign words_loaded       = words_q;

   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      word_d  = word_q;
      bcnt_d  = bcnt_q;
      words_d = words_q;
`ifdef CHECKSUM_EN
      xor_d   = xor_q;
`endif
      restart = 1'b0;

      case (state_q)
         S_IDLE: restart = load_start;
         S_RECEIVE: begin
            if (load_start) begin
               restart = 1'b1;
            end else if (accept) begin
               word_d = {word_q[23:0], byte_data};
               bcnt_d = bcnt_q + 2'd1;
`ifdef CHECKSUM_EN
               xor_d  = xor_q ^ byte_data;
`endif
               if (bcnt_q == 2'd3) state_d = S_WRITE;
            end
         end
         // The strobe is already on the bus this cycle, so a restart here still lets it land.
         S_WRITE: begin
            words_d = words_q + WORDS_ONE;
            if (load_start) begin
               restart = 1'b1;
            end else if (word_q == 32'h0000_0000) begin
`ifdef CHECKSUM_EN
               state_d = S_CHECK;
`else
               state_d = S_START;
`endif
            end else if (addr_q == LAST_ADDR) begin
               state_d = S_ERROR;
            end else begin
               addr_d  = addr_q + ADDR_ONE;
               state_d = S_RECEIVE;
            end
         end
         S_START: state_d = S_DONE;
         S_DONE:  restart = load_start;
         S_ERROR: restart = load_start;
`ifdef CHECKSUM_EN
         S_CHECK: begin
            if (load_start) begin
               restart = 1'b1;
            end else if (accept) begin
               state_d = (byte_data == xor_q) ? S_START : S_ERROR;
            end
         end
`endif
         default: state_d = S_IDLE;
      endcase

      if (restart) begin
         state_d = S_RECEIVE;
         addr_d  = '0;
         word_d  = '0;
         bcnt_d  = '0;
         words_d = '0;
`ifdef CHECKSUM_EN
         xor_d   = '0;
`endif
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q <= S_IDLE;
         addr_q  <= '0;
         word_q  <= '0;
         bcnt_q  <= '0;
         words_q <= '0;
`ifdef CHECKSUM_EN
         xor_q   <= '0;
`endif
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         word_q  <= word_d;
         bcnt_q  <= bcnt_d;
         words_q <= words_d;
`ifdef CHECKSUM_EN
         xor_q   <= xor_d;
`endif
      end
   end

endmodule

// File: tb/tb_program_loader.sv
// Scoreboard bench for program_loader: a full-size loader and a 4-word loader share one byte stream;
// expected writes come from packing the byte list, monitors compare every write strobe.
module tb_program_loader;

   typedef logic [7:0] bq_t[$];
   typedef struct {
      int          addr;
      logic [31:0] data;
   } wr_t;

   logic clock = 1'b0;
   logic reset;
   logic ls_a, ls_b;
   logic byte_valid;
   logic [7:0] byte_data;

   logic        ready_a, we_a, hold_a, start_a, done_a, err_a;
   logic [9:0]  wa_a;
   logic [31:0] wd_a;
   logic [10:0] wl_a;
   logic        ready_b, we_b, hold_b, start_b, done_b, err_b;
   logic [1:0]  wa_b;
   logic [31:0] wd_b;
   logic [2:0]  wl_b;

   wr_t q_a[$];
   wr_t q_b[$];
   wr_t ea, eb;
   int n_chk = 0, n_fail = 0;
   int strobes_a = 0, strobes_b = 0, starts_a = 0, starts_b = 0;

   always #5 clock = ~clock;

   program_loader #(.ADDR_WIDTH(10)) dut_a (
      .clock(clock), .reset(reset), .load_start(ls_a), .byte_data(byte_data),
      .byte_valid(byte_valid), .byte_ready(ready_a), .imem_write_enable(we_a),
      .imem_write_address(wa_a), .imem_write_data(wd_a), .processor_hold(hold_a),
      .processor_start(start_a), .words_loaded(wl_a), .load_done(done_a), .load_error(err_a));

   program_loader #(.ADDR_WIDTH(2)) dut_b (
      .clock(clock), .reset(reset), .load_start(ls_b), .byte_data(byte_data),
      .byte_valid(byte_valid), .byte_ready(ready_b), .imem_write_enable(we_b),
      .imem_write_address(wa_b), .imem_write_data(wd_b), .processor_hold(hold_b),
      .processor_start(start_b), .words_loaded(wl_b), .load_done(done_b), .load_error(err_b));

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic fail_now(input string name);
      n_chk++;
      n_fail++;
      $display("FAIL %s", name);
   endtask

   always @(negedge clock) begin
      if (!reset) begin
         if (we_a) begin
            strobes_a++;
            chk("ready_low_in_write_a", 64'(ready_a), 64'(0));
            if (q_a.size() == 0) begin
               fail_now($sformatf("unexpected_write_a addr %0d data %0h", wa_a, wd_a));
            end else begin
               ea = q_a.pop_front();
               chk("waddr_a", 64'(wa_a), 64'(ea.addr));
               chk("wdata_a", 64'(wd_a), 64'(ea.data));
            end
         end
         if (start_a) begin
            starts_a++;
            chk("hold_at_start_a", 64'(hold_a), 64'(0));
         end
      end
   end

   always @(negedge clock) begin
      if (!reset) begin
         if (we_b) begin
            strobes_b++;
            if (q_b.size() == 0) begin
               fail_now($sformatf("unexpected_write_b addr %0d data %0h", wa_b, wd_b));
            end else begin
               eb = q_b.pop_front();
               chk("waddr_b", 64'(wa_b), 64'(eb.addr));
               chk("wdata_b", 64'(wd_b), 64'(eb.data));
            end
         end
         if (start_b) starts_b++;
      end
   end

   // All tasks start and end 1 time unit after a rising edge.
   task automatic pulse_start(input bit sel);
      if (sel) ls_b = 1'b1; else ls_a = 1'b1;
      byte_valid = 1'b1;
      byte_data  = 8'($urandom);
      @(negedge clock);
      chk("ready_low_with_load_start", 64'(sel ? ready_b : ready_a), 64'(0));
      @(posedge clock); #1;
      ls_a = 1'b0;
      ls_b = 1'b0;
      byte_valid = 1'b0;
   endtask

   task automatic send_byte(input bit sel, input logic [7:0] b, input bit gaps);
      int k;
      if (gaps && $urandom_range(0, 2) == 0) begin
         byte_valid = 1'b0;
         byte_data  = 8'($urandom);
         repeat ($urandom_range(1, 4)) begin
            @(posedge clock); #1;
         end
      end
      byte_data  = b;
      byte_valid = 1'b1;
      for (k = 0; k < 40; k++) begin
         @(negedge clock);
         if ((sel ? ready_b : ready_a) === 1'b1) break;
      end
      if (k == 40) fail_now("byte_accept_timeout");
      @(posedge clock); #1;
      byte_valid = 1'b0;
   endtask

   // cs_mode: 0 no checksum byte, 1 correct checksum, 2 corrupted checksum
   task automatic run_load(input bit sel, input bq_t bytes, input bit gaps, input int cs_mode,
                           input bit exp_ok);
      int maxw = sel ? 4 : 1024;
      int nw = 0;
      int s0, st0, k;
      logic [7:0] x = 8'h00;
      logic [31:0] w;
      wr_t e;
      for (int i = 0; i + 3 < bytes.size(); i += 4) begin
         w = {bytes[i], bytes[i+1], bytes[i+2], bytes[i+3]};
         e.addr = nw;
         e.data = w;
         if (sel) q_b.push_back(e); else q_a.push_back(e);
         nw++;
         if (w == 32'h0 || nw == maxw) break;
      end
      s0  = sel ? strobes_b : strobes_a;
      st0 = sel ? starts_b : starts_a;
      pulse_start(sel);
      foreach (bytes[i]) begin
         send_byte(sel, bytes[i], gaps);
         x = x ^ bytes[i];
      end
`ifdef CHECKSUM_EN
      if (cs_mode == 1) send_byte(sel, x, gaps);
      if (cs_mode == 2) send_byte(sel, x ^ 8'h07, gaps);
`else
      if (cs_mode > 2) fail_now("bad_cs_mode");
`endif
      for (k = 0; k < 40; k++) begin
         @(negedge clock);
         if ((sel ? (done_b | err_b) : (done_a | err_a)) === 1'b1) break;
      end
      if (k == 40) fail_now("load_finish_timeout");
      chk("words_loaded", 64'(sel ? 32'(wl_b) : 32'(wl_a)), 64'(nw));
      chk("load_done", 64'(sel ? done_b : done_a), 64'(exp_ok));
      chk("load_error", 64'(sel ? err_b : err_a), 64'(!exp_ok));
      chk("processor_hold", 64'(sel ? hold_b : hold_a), 64'(!exp_ok));
      chk("start_pulses", 64'((sel ? starts_b : starts_a) - st0), 64'(exp_ok));
      chk("write_strobes", 64'((sel ? strobes_b : strobes_a) - s0), 64'(nw));
      chk("pending_writes", 64'(sel ? q_b.size() : q_a.size()), 64'(0));
      @(posedge clock); #1;
   endtask

   initial begin
      bq_t prog, p, rnd;
      int n0;
      logic [31:0] w;
      reset = 1'b1;
      ls_a = 1'b0;
      ls_b = 1'b0;
      byte_valid = 1'b0;
      byte_data = 8'h00;
      repeat (2) @(posedge clock);
      #1;
      chk("rst_hold", 64'(hold_a), 64'(1));
      chk("rst_outputs", 64'({we_a, start_a, done_a, err_a, ready_a}), 64'(0));
      chk("rst_addr_data_words", 64'({wa_a, wd_a, wl_a}), 64'(0));
      chk("rst_hold_b", 64'(hold_b), 64'(1));
      reset = 1'b0;
      repeat (3) begin
         @(posedge clock); #1;
      end
      chk("idle_no_writes", 64'(strobes_a + strobes_b), 64'(0));

      prog = '{8'h21, 8'h00, 8'h00, 8'h0A, 8'h22, 8'h00, 8'h00, 8'h14};
      repeat (5) prog = {prog, 8'h91, 8'h11, 8'h00, 8'h00};
      prog = {prog, 8'h51, 8'h12, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
      run_load(1'b0, prog, 1'b0, 1, 1'b1);
      run_load(1'b0, prog, 1'b1, 1, 1'b1);

      pulse_start(1'b0);
      send_byte(1'b0, 8'h21, 1'b0);
      send_byte(1'b0, 8'h00, 1'b0);
      p = '{8'h22, 8'h00, 8'h00, 8'h14, 8'h00, 8'h00, 8'h00, 8'h00};
      run_load(1'b0, p, 1'b0, 1, 1'b1);

      for (int t = 0; t < 3; t++) begin
         rnd = {};
         repeat ($urandom_range(1, 12)) begin
            w = $urandom;
            if (w == 32'h0) w = 32'h1;
            rnd = {rnd, w[31:24], w[23:16], w[15:8], w[7:0]};
         end
         rnd = {rnd, 8'h00, 8'h00, 8'h00, 8'h00};
         run_load(1'b0, rnd, 1'b1, 1, 1'b1);
      end

      rnd = {};
      repeat (4) begin
         w = $urandom;
         if (w == 32'h0) w = 32'h80;
         rnd = {rnd, w[31:24], w[23:16], w[15:8], w[7:0]};
      end
      run_load(1'b1, rnd, 1'b1, 0, 1'b0);

`ifdef CHECKSUM_EN
      p = '{8'h21, 8'h00, 8'h00, 8'h0A, 8'h00, 8'h00, 8'h00, 8'h00};
      run_load(1'b0, p, 1'b0, 1, 1'b1);
      run_load(1'b0, p, 1'b0, 2, 1'b0);
`endif

      pulse_start(1'b0);
      send_byte(1'b0, 8'h33, 1'b0);
      send_byte(1'b0, 8'h44, 1'b0);
      @(negedge clock);
      #2;
      reset = 1'b1;
      #1;
      chk("async_rst_hold", 64'(hold_a), 64'(1));
      chk("async_rst_outputs", 64'({we_a, start_a, done_a, err_a, ready_a}), 64'(0));
      chk("async_rst_addr_data_words", 64'({wa_a, wd_a, wl_a}), 64'(0));
      @(posedge clock); #1;
      reset = 1'b0;
      n0 = strobes_a;
      byte_valid = 1'b1;
      byte_data = 8'h5A;
      repeat (6) begin
         @(posedge clock); #1;
      end
      chk("post_rst_idle_ready", 64'(ready_a), 64'(0));
      chk("post_rst_idle_hold", 64'(hold_a), 64'(1));
      chk("post_rst_no_strobe", 64'(strobes_a - n0), 64'(0));
      byte_valid = 1'b0;

      run_load(1'b0, prog, 1'b1, 1, 1'b1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
